stream_frame_slicer: RTL and testbench

STREAM_FRAME_SLICER -- requirements
Module: stream_frame_slicer

---
 rtl/stream_frame_slicer.sv | 103 ++++++++++
 tb/tb_stream_frame_slicer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stream_frame_slicer.sv
// stream_frame_slicer
//   Cuts a beat stream into frames of frame_len beats. An upstream wr_last
//   ends a frame early. Beats pass through a 2-entry skid buffer that holds
//   {data, last}. The buffer gives one cycle of latency and sustains one
//   beat per cycle.
// Ports
//   clock, rst            : clock, asynchronous active-high reset
//   wr_data/wr_vld/wr_last: input beat, valid and upstream end-of-frame
//   wr_ready              : buffer has a free entry (registered state only)
//   frame_len             : target length, sampled on a frame's first beat
//   rd_data/rd_vld/rd_last: head-of-buffer beat, valid and frame end
//   rd_ready              : downstream accept
//   frame_cnt             : frames emitted, wraps at 16 bits
//   short_err             : one-cycle pulse when wr_last cut a frame short
module stream_frame_slicer #(
  parameter int DSIZE   = 8,
  parameter int MAX_LEN = 16,
  parameter int LSIZE   = $clog2(MAX_LEN+1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ready,
  input  logic             wr_last,
  input  logic [LSIZE-1:0] frame_len,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic [15:0]      frame_cnt,
  output logic             short_err
);

  logic [DSIZE-1:0] r_mem_d [2];
  logic             r_mem_l [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_occ;
  logic [LSIZE-1:0] r_beat, r_len;
  logic [15:0]      r_fcnt;
  logic             r_serr;

  logic             w_wr, w_rd;
  logic [LSIZE-1:0] w_len_in, w_len, w_len_m1;
  logic             w_last, w_short;

  assign wr_ready = (r_occ != 2'd2);
  assign rd_vld   = (r_occ != 2'd0);
  // Masked while empty so a drained buffer reads back as zeros, like after reset.
  assign rd_data  = rd_vld ? r_mem_d[r_rptr] : '0;
  assign rd_last  = rd_vld & r_mem_l[r_rptr];
  assign frame_cnt = r_fcnt;
  assign short_err = r_serr;

  assign w_wr = wr_vld & wr_ready;
  assign w_rd = rd_vld & rd_ready;

  // A length of 0 is treated as 1. Lengths above MAX_LEN are clamped.
  always_comb begin
    w_len_in = frame_len;
    if (frame_len == '0)                w_len_in = LSIZE'(1);
    else if (frame_len > LSIZE'(MAX_LEN)) w_len_in = LSIZE'(MAX_LEN);
  end

  // On the first beat, use the length being latched. Later beats use the stored length.
  assign w_len    = (r_beat == '0) ? w_len_in : r_len;
  assign w_len_m1 = w_len - LSIZE'(1);
  assign w_last   = (r_beat == w_len_m1) | wr_last;
  assign w_short  = wr_last & (r_beat < w_len_m1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_mem_d[0] <= '0;
      r_mem_d[1] <= '0;
      r_mem_l[0] <= 1'b0;
      r_mem_l[1] <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_beat     <= '0;
      r_len      <= '0;
      r_fcnt     <= '0;
      r_serr     <= 1'b0;
    end else begin
      r_serr <= w_wr & w_short;
      if (w_wr) begin
        r_mem_d[r_wptr] <= wr_data;
        r_mem_l[r_wptr] <= w_last;
        r_wptr          <= ~r_wptr;
        if (r_beat == '0) r_len <= w_len_in;
        r_beat <= w_last ? '0 : r_beat + LSIZE'(1);
      end
      if (w_rd) begin
        r_rptr <= ~r_rptr;
        if (rd_last) r_fcnt <= r_fcnt + 16'd1;
      end
      // Occupancy is unchanged when a read and a write happen in the same cycle.
      if (w_wr && !w_rd)      r_occ <= r_occ + 2'd1;
      else if (w_rd && !w_wr) r_occ <= r_occ - 2'd1;
    end
  end

endmodule

// File: tb/tb_stream_frame_slicer.sv
module tb_stream_frame_slicer;
  localparam int DSIZE = 8, MAX_LEN = 16, LSIZE = $clog2(MAX_LEN+1);

  logic             clock, rst;
  logic [DSIZE-1:0] wr_data, rd_data;
  logic             wr_vld, wr_ready, wr_last, rd_vld, rd_ready, rd_last, short_err;
  logic [LSIZE-1:0] frame_len;
  logic [15:0]      frame_cnt;

  int n_chk = 0, n_bad = 0;

  stream_frame_slicer #(.DSIZE(DSIZE), .MAX_LEN(MAX_LEN), .LSIZE(LSIZE)) dut (
    .clock(clock), .rst(rst), .wr_data(wr_data), .wr_vld(wr_vld),
    .wr_ready(wr_ready), .wr_last(wr_last), .frame_len(frame_len),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_ready(rd_ready),
    .rd_last(rd_last), .frame_cnt(frame_cnt), .short_err(short_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_vld = 1'b0; wr_last = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Offer n consecutive beats d0, d0-1, ... with rd_ready high. Each output
  // beat must follow its input by one cycle, and rd_last must fall on every
  // per-th beat.
  task automatic stream(input int n, input logic [7:0] d0, input int per);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        wr_vld = 1'b1; wr_data = 8'(d0 - 8'(i));
      end else
        wr_vld = 1'b0;
      if (i > 0) begin
        chk("s_vld",  rd_vld, 1);
        chk("s_data", rd_data, 8'(d0 - 8'(i-1)));
        chk("s_last", rd_last, (i % per) == 0);
      end
      if (i < n) chk("s_wrdy", wr_ready, 1);
      step();
      chk("s_serr", short_err, 0);
    end
    chk("s_empty", rd_vld, 0);
  endtask

  initial begin
    rst = 1'b1; wr_vld = 1'b0; wr_last = 1'b0; wr_data = '0;
    rd_ready = 1'b1; frame_len = 5'd4;
    #2;
    chk("rst_vld",  rd_vld, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_wrdy", wr_ready, 1);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_serr", short_err, 0);
    step(); step();
    rst = 1'b0;

    // Streaming: 12 beats with length 4 give 3 frames and no stalls.
    stream(12, 8'hFF, 4);
    chk("str_fcnt", frame_cnt, 3);

    // Backpressure
    do_reset();
    rd_ready = 1'b0; frame_len = 5'd4;
    wr_vld = 1'b1; wr_data = 8'hFF; step();
    chk("bp_wrdy1", wr_ready, 1); chk("bp_d1", rd_data, 8'hFF);
    wr_data = 8'hFE; step();
    chk("bp_wrdy2", wr_ready, 0); chk("bp_d2", rd_data, 8'hFF);
    wr_data = 8'hFD; step();
    chk("bp_wrdy3", wr_ready, 0); chk("bp_d3", rd_data, 8'hFF);
    rd_ready = 1'b1; step();
    chk("bp_o2", rd_data, 8'hFE);
    step();
    wr_vld = 1'b0;
    chk("bp_o3", rd_data, 8'hFD); chk("bp_o3l", rd_last, 0);
    step();
    chk("bp_empty", rd_vld, 0);

    // Short frame: length 8 cut at beat 3. Then a length-2 frame whose
    // wr_last coincides with the length end, which is not an error.
    do_reset();
    frame_len = 5'd8;
    wr_vld = 1'b1; wr_data = 8'hA0; step();
    frame_len = 5'd2;  // must be ignored mid-frame
    wr_data = 8'hA1; step();
    chk("sh_l1", rd_last, 0);
    wr_data = 8'hA2; wr_last = 1'b1; step();
    wr_last = 1'b0;
    chk("sh_d", rd_data, 8'hA2); chk("sh_l", rd_last, 1); chk("sh_err", short_err, 1);
    wr_data = 8'hB0; step();
    chk("sh_err_off", short_err, 0);
    chk("nx_l0", rd_last, 0);
    wr_data = 8'hB1; wr_last = 1'b1; step();
    wr_vld = 1'b0; wr_last = 1'b0;
    chk("nx_d", rd_data, 8'hB1); chk("nx_l1", rd_last, 1); chk("nx_err", short_err, 0);
    step();
    chk("sh_fcnt", frame_cnt, 2);

    // Length edge cases
    do_reset();
    frame_len = 5'd0;
    stream(3, 8'h30, 1);
    frame_len = 5'(MAX_LEN + 5);
    stream(17, 8'h80, 16);
    chk("len_fcnt", frame_cnt, 4);

    // Reset mid-frame with one beat in the buffer
    do_reset();
    frame_len = 5'd4;
    wr_vld = 1'b1; wr_data = 8'h11; step();
    wr_data = 8'h12; step();
    wr_vld = 1'b0;
    chk("mr_pre", rd_vld, 1);
    rst = 1'b1; #1;
    chk("mr_vld", rd_vld, 0); chk("mr_fcnt", frame_cnt, 0);
    chk("mr_data", rd_data, 0); chk("mr_wrdy", wr_ready, 1);
    step(); rst = 1'b0;
    stream(4, 8'h20, 4);
    chk("mr_fcnt2", frame_cnt, 1);

    // frame_cnt wrap
    do_reset();
    frame_len = 5'd1; wr_vld = 1'b1; wr_data = 8'h55;
    for (int i = 0; i < 65535; i++) step();
    wr_vld = 1'b0; step();
    chk("wr_ffff", frame_cnt, 16'hFFFF);
    wr_vld = 1'b1; step();
    wr_vld = 1'b0; step();
    chk("wr_zero", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
